// File: rtl/scan_capture_pkg.sv
// scan_capture_pkg: shared types and constants for the display scan capture block.
package scan_capture_pkg;

    typedef enum logic [1:0] {SYNC, CAPTURE, COMPARE, PUBLISH} state_t;

    localparam int DIGITS = 4;
    localparam int VALUE_W = 14;
    localparam logic [VALUE_W-1:0] BEST_INIT = 14'h3FFF;

    function automatic logic is_digit(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/display_scan_capture_bcd4_to_bin.sv
// bcd4_to_bin: combinational four-digit BCD to binary converter, registered by the parent.
module bcd4_to_bin
    import scan_capture_pkg::*;
(
    input  logic [4*DIGITS-1:0] i_bcd,
    output logic [VALUE_W-1:0]  o_bin
);

    assign o_bin = VALUE_W'(i_bcd[15:12]) * 14'd1000
                 + VALUE_W'(i_bcd[11:8])  * 14'd100
                 + VALUE_W'(i_bcd[7:4])   * 14'd10
                 + VALUE_W'(i_bcd[3:0]);

endmodule

// File: rtl/display_scan_capture.sv
// display_scan_capture: rebuilds and confirms the four-digit value from a scanned display bus.
// Optional minimum tracking on best_bin when BEST_TRACK_EN is defined.
module display_scan_capture
    import scan_capture_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int CONFIRM_FRAMES = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [3:0]           ms,
    input  logic [1:0]           display_select,
    output logic [4*DIGITS-1:0]  value_bcd,
    output logic [VALUE_W-1:0]   value_bin,
    output logic                 valid,
    output logic                 scan_err
`ifdef BEST_TRACK_EN
    ,
    output logic [VALUE_W-1:0]   best_bin
`endif
);

    localparam int DW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] TMO       = DW'(TIMEOUT_CYCLES);
    localparam logic [DW-1:0] TMO_M1    = DW'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] SAMPLE_AT = DW'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 1 : 1);
    localparam logic [3:0]    CONF      = 4'(CONFIRM_FRAMES);

    state_t               r_state;
    logic [1:0]           r_prev_sel;
    logic [DW-1:0]        r_dwell;
    logic [1:0]           r_exp;
    logic [4*DIGITS-1:0]  r_frame;
    logic [4*DIGITS-1:0]  r_prev_frame;
    logic [3:0]           r_match;

    logic                 w_same;
    logic [DW-1:0]        w_dwell_inc;
    logic                 w_sample;
    logic                 w_timeout;
    logic                 w_digit_ok;
    logic [3:0]           w_match_nxt;
    logic [VALUE_W-1:0]   w_bin;

    // The dwell counter holds (cycles on this index - 1); the sample fires as it steps onto SAMPLE_AT.
    always_comb begin
        w_same      = display_select == r_prev_sel;
        w_dwell_inc = (r_dwell == TMO) ? r_dwell : r_dwell + 1'b1;
        w_sample    = w_same && w_dwell_inc == SAMPLE_AT;
        w_timeout   = w_same && r_dwell == TMO_M1;
        w_digit_ok  = is_digit(ms);
        w_match_nxt = (r_frame == r_prev_frame) ? ((r_match == 4'hF) ? r_match : r_match + 1'b1) : 4'd1;
    end

    bcd4_to_bin u_bcd4_to_bin (
        .i_bcd (r_frame),
        .o_bin (w_bin)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_sel <= 2'd0;
            r_dwell    <= '0;
        end else begin
            r_prev_sel <= display_select;
            r_dwell    <= w_same ? w_dwell_inc : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SYNC;
            r_exp        <= 2'd0;
            r_frame      <= '0;
            r_prev_frame <= '0;
            r_match      <= 4'd0;
            value_bcd    <= '0;
            value_bin    <= '0;
            valid        <= 1'b0;
            scan_err     <= 1'b0;
`ifdef BEST_TRACK_EN
            best_bin     <= BEST_INIT;
`endif
        end else begin
            valid    <= 1'b0;
            scan_err <= 1'b0;
            if (!enable) begin
                r_state <= SYNC;
                r_match <= 4'd0;
            end else begin
                case (r_state)
                    // Locking onto index 0 also captures its digit, so the first frame is not lost.
                    SYNC: begin
                        if (w_sample && display_select == 2'd0 && w_digit_ok) begin
                            r_frame[3:0] <= ms;
                            r_exp        <= 2'd1;
                            r_state      <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (w_timeout) begin
                            scan_err <= 1'b1;
                            r_state  <= SYNC;
                        end else if (w_sample) begin
                            if (display_select != r_exp || !w_digit_ok) begin
                                scan_err <= 1'b1;
                                r_state  <= SYNC;
                            end else begin
                                r_frame[{display_select, 2'b00} +: 4] <= ms;
                                r_exp <= r_exp + 1'b1;
                                if (r_exp == 2'd3)
                                    r_state <= COMPARE;
                            end
                        end
                    end
                    COMPARE: begin
                        r_match      <= w_match_nxt;
                        r_prev_frame <= r_frame;
                        r_exp        <= 2'd0;
                        r_state      <= (w_match_nxt >= CONF && r_frame != value_bcd) ? PUBLISH : CAPTURE;
                    end
                    PUBLISH: begin
                        value_bcd <= r_frame;
                        value_bin <= w_bin;
                        valid     <= 1'b1;
`ifdef BEST_TRACK_EN
                        best_bin  <= (w_bin < best_bin) ? w_bin : best_bin;
`endif
                        r_exp     <= 2'd0;
                        r_state   <= CAPTURE;
                    end
                    default: r_state <= SYNC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_scan_capture.sv
// tb_display_scan_capture: directed self-checking bench for display_scan_capture.
module tb_display_scan_capture;
    import scan_capture_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  ms;
    logic [1:0]  display_select;
    logic [15:0] value_bcd;
    logic [13:0] value_bin;
    logic        valid;
    logic        scan_err;
`ifdef BEST_TRACK_EN
    logic [13:0] best_bin;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_both = 0;
    int v0, e0;

    display_scan_capture #(
        .SETTLE_CYCLES  (4),
        .CONFIRM_FRAMES (2),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .ms             (ms),
        .display_select (display_select),
        .value_bcd      (value_bcd),
        .value_bin      (value_bin),
        .valid          (valid),
        .scan_err       (scan_err)
`ifdef BEST_TRACK_EN
        ,
        .best_bin       (best_bin)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) n_valid++;
        if (scan_err) n_err++;
        if (valid && scan_err) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dwell(input logic [1:0] s, input logic [3:0] d, input int n);
        display_select = s;
        ms = d;
        repeat (n) tick();
    endtask

    // Digit 3 is sampled on the 4th edge of its dwell, so a publish shows on the 6th.
    task automatic frame(input logic [15:0] bcd, input bit pub);
        for (int i = 0; i < 3; i++) dwell(i[1:0], bcd[4*i +: 4], 10);
        display_select = 2'd3;
        ms = bcd[15:12];
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("valid_timing", valid, pub && k == 6);
        end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        ms = 4'd0;
        display_select = 2'd3;
        repeat (2) tick();
        chk("rst_bcd", value_bcd, 0);
        chk("rst_bin", value_bin, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", scan_err, 0);
`ifdef BEST_TRACK_EN
        chk("rst_best", best_bin, 14'h3FFF);
`endif
        rst = 1'b0;
        dwell(2'd3, 4'd0, 10);

        v0 = n_valid;
        frame(16'h1230, 1'b0);
        frame(16'h1230, 1'b1);
        chk("bcd_1230", value_bcd, 16'h1230);
        chk("bin_1230", value_bin, 1230);
        frame(16'h1230, 1'b0);
        chk("valid_once_1230", n_valid - v0, 1);

        frame(16'h1450, 1'b0);
        frame(16'h1450, 1'b1);
        chk("bcd_1450", value_bcd, 16'h1450);
        chk("bin_1450", value_bin, 1450);
`ifdef BEST_TRACK_EN
        chk("best_1230", best_bin, 1230);
`endif

        v0 = n_valid; e0 = n_err;
        dwell(2'd0, 4'd0, 10);
        dwell(2'd1, 4'd5, 10);
        dwell(2'd3, 4'd4, 10);
        chk("order_err", n_err - e0, 1);
        chk("order_no_valid", n_valid - v0, 0);
        frame(16'h2718, 1'b0);
        frame(16'h2718, 1'b1);
        chk("bcd_2718", value_bcd, 16'h2718);
        chk("bin_2718", value_bin, 2718);

        e0 = n_err; v0 = n_valid;
        dwell(2'd0, 4'd5, 10);
        dwell(2'd1, 4'hB, 10);
        dwell(2'd2, 4'd0, 10);
        dwell(2'd3, 4'd0, 10);
        chk("digit_err", n_err - e0, 1);
        chk("digit_no_valid", n_valid - v0, 0);
        chk("digit_bcd_held", value_bcd, 16'h2718);

        dwell(2'd0, 4'd1, 10);
        dwell(2'd1, 4'd2, 10);
        dwell(2'd2, 4'd3, 50);
        chk("tmo_before", scan_err, 0);
        tick();
        chk("tmo_err", scan_err, 1);
        chk("tmo_state", dut.r_state, SYNC);
        tick();
        chk("tmo_pulse", scan_err, 0);

        e0 = n_err; v0 = n_valid;
        dwell(2'd0, 4'd4, 10);
        dwell(2'd1, 4'd9, 10);
        dwell(2'd3, 4'd9, 2);
        dwell(2'd2, 4'd9, 10);
        dwell(2'd3, 4'd1, 10);
        frame(16'h1994, 1'b1);
        chk("glitch_no_err", n_err - e0, 0);
        chk("glitch_valid", n_valid - v0, 1);
        chk("bcd_1994", value_bcd, 16'h1994);
        chk("bin_1994", value_bin, 1994);
`ifdef BEST_TRACK_EN
        chk("best_kept", best_bin, 1230);
`endif

        dwell(2'd0, 4'd7, 10);
        dwell(2'd1, 4'd7, 5);
        rst = 1'b1;
        tick();
        chk("mid_rst_bcd", value_bcd, 0);
        chk("mid_rst_bin", value_bin, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_err", scan_err, 0);
        chk("mid_rst_state", dut.r_state, SYNC);
`ifdef BEST_TRACK_EN
        chk("mid_rst_best", best_bin, 14'h3FFF);
`endif
        rst = 1'b0;
        dwell(2'd3, 4'd0, 10);
        frame(16'h0042, 1'b0);
        frame(16'h0042, 1'b1);
        chk("bcd_0042", value_bcd, 16'h0042);
        chk("bin_0042", value_bin, 42);
`ifdef BEST_TRACK_EN
        chk("best_42", best_bin, 42);
`endif
        chk("no_overlap", n_both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scan_capture.md
# display_scan_capture

Reads the time-multiplexed digit stream produced by the reaction-time benchmark (`ms` digit plus `display_select` scan index) and rebuilds the full four-digit result. It sits on the consumer side of the display bus, in parallel with the seven-segment decoder. It publishes a confirmed BCD and binary value with a one-cycle valid pulse, so that self-checking benches and logging logic can read results without decoding segments.

## Interface
- `SETTLE_CYCLES`, 4: consecutive cycles `display_select` must hold before its digit is sampled; range 1..255.
- `CONFIRM_FRAMES`, 2: consecutive identical complete frames required before publishing; range 1..15.
- `TIMEOUT_CYCLES`, 100000: maximum dwell on one scan index during capture before the frame is aborted.
- `clk` in 1: system clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `enable` in 1: capture enable. When low, the block is forced to SYNC and ignores the bus.
- `ms` in 4: digit currently driven on the display bus.
- `display_select` in 2: scan index. 0 = units, 1 = tens, 2 = hundreds, 3 = thousands.
- `value_bcd` out 16: last published value, thousands in [15:12].
- `value_bin` out 14: binary equivalent of `value_bcd`, 0..9999.
- `valid` out 1: one-cycle pulse when a new value is published.
- `scan_err` out 1: one-cycle pulse on an out-of-order index, a digit greater than 9, or a timeout.
- `best_bin` out 14: minimum published value since reset. Present only under `BEST_TRACK_EN`.

## Operation
- States:
  - SYNC: wait for `display_select` == 0 to be stable for SETTLE_CYCLES.
  - CAPTURE: collect digits 0..3.
  - COMPARE: frame done. Check it against the previous frame.
  - PUBLISH: drive outputs.
- Dwell counter:
  - Clears whenever `display_select` differs from its value in the previous cycle.
  - Saturates at TIMEOUT_CYCLES.
  - A digit is sampled exactly once per dwell, in the cycle the counter reaches SETTLE_CYCLES-1.
- Order check: the expected index increments mod 4. A stable index that is not the expected one causes `scan_err` and a transition to SYNC. The partial frame is discarded.
- Digit check: a sampled `ms` greater than 9 causes `scan_err`, the frame is discarded, and the block goes to SYNC.
- Timeout: if the dwell counter saturates in CAPTURE, `scan_err` pulses and the block goes to SYNC.
- Sampling index 3 completes the frame and moves to COMPARE.
  - If the frame equals the previous frame, the match count increments (saturating). Otherwise the match count is set to 1.
  - When the match count reaches CONFIRM_FRAMES and the frame differs from `value_bcd`, the block goes to PUBLISH. Otherwise it returns to CAPTURE expecting index 0.
- PUBLISH:
  - Registers `value_bcd`, `value_bin` = 1000·d3 + 100·d2 + 10·d1 + d0, and `valid` = 1.
  - Then returns to CAPTURE.
  - An unchanged value is never republished.
- `enable` falling mid-frame: go to SYNC next cycle and clear the match count. `value_*` are held.
- `rst` mid-operation: all state and outputs return to reset values on the next edge. A frame in progress is lost.

## Timing
- Reset values: `value_bcd` = 0, `value_bin` = 0, `valid` = 0, `scan_err` = 0, `best_bin` = 14'h3FFF, state SYNC, match count 0.
- All outputs are registered. No combinational path from inputs to outputs.
- `valid` rises 2 cycles after the edge on which digit 3 of the confirming frame is sampled (COMPARE, then PUBLISH). It is high for exactly 1 cycle.
- `value_bcd` and `value_bin` change in the same cycle `valid` rises and are held until the next publish.
- `scan_err` and `valid` are never high in the same cycle.
- A select change and the sample cycle coinciding: the change wins and no sample is taken.
- Minimum dwell for capture is SETTLE_CYCLES. A shorter dwell is treated as a glitch and causes no error by itself.

## Configuration
- `BEST_TRACK_EN` defined:
  - `best_bin` port exists.
  - It updates in the publish cycle to min(`best_bin`, new `value_bin`).
  - Returns to 14'h3FFF on `rst`.
- Not defined: the port and the comparator are absent. All other behaviour is identical.

## Structure
- Shared package `scan_capture_pkg`:
  - state enum {SYNC, CAPTURE, COMPARE, PUBLISH}
  - `DIGITS` = 4
  - `VALUE_W` = 14
  - `BEST_INIT` = 14'h3FFF
- One sub-module: `bcd4_to_bin`, a combinational 16-bit BCD to 14-bit binary converter registered by the parent.

## Test plan
- Scan select 0..3 carrying digits 0,3,2,1, dwell 10 cycles, three identical frames: exactly one `valid`, `value_bcd` = 16'h1230, `value_bin` = 1230, 2 cycles after the second frame's digit 3 sample.
- After 1230 is published, switch to digits giving 1450 for 2 frames: `valid` again with `value_bin` = 1450. `best_bin` = 1230 when `BEST_TRACK_EN` is defined.
- Index sequence 0,1,3 mid-frame: `scan_err` pulse on the stable 3, no `valid`. After resync, recovery to a correct publish within 2 good frames.
- `ms` = 4'hB on the tens index: `scan_err`, frame discarded, `value_bcd` unchanged.
- Select stuck at 2 for TIMEOUT_CYCLES (override to 50): `scan_err` at cycle 50, state SYNC.
- 2-cycle select glitch with SETTLE_CYCLES = 4: no sample, no error. Assert `rst` mid-frame: all outputs at reset values next cycle.
